// File: rtl/serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl_if
// Purpose  : Bundles the operation handshake, result handshake and the
//            external 4-bit adder-slice connection of serial_add_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_add_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  // operation request
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_sub;
  logic         cin;

  // external adder slice
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;

  // result
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  // master: requester, result consumer and adder slice
  modport master (
    output in_valid, op_a, op_b, op_sub, cin, out_ready, add_sum, add_cout,
    input  in_ready, add_a, add_b, add_cin, out_valid, result, carry_out, overflow
  );

  // slave: the controller itself
  modport slave (
    input  in_valid, op_a, op_b, op_sub, cin, out_ready, add_sum, add_cout,
    output in_ready, add_a, add_b, add_cin, out_valid, result, carry_out, overflow
  );
endinterface
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_add_ctrl
// Purpose  : Nibble-serial add/subtract controller. Feeds one 4-bit slice of
//            the captured operands per cycle to an external adder slice and
//            assembles the W-bit result, final carry and signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0]       c_IDLE = 2'd0;
  localparam logic [1:0]       c_RUN  = 2'd1;
  localparam logic [1:0]       c_DONE = 2'd2;
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(NIBBLES - 1);

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;      // already inverted for subtraction
  logic             r_carry;
  logic [W-1:0]     r_result;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic             w_ovf;

  // Current slice of the captured operands
  assign w_a_nib = r_a[{r_idx, 2'b00} +: 4];
  assign w_b_nib = r_b[{r_idx, 2'b00} +: 4];

  // Carry into bit 3 of the slice is recovered as a^b^sum; overflow is that
  // carry XOR the slice carry-out (only meaningful on the top nibble).
  assign w_ovf = (w_a_nib[3] ^ w_b_nib[3] ^ bus.add_sum[3]) ^ bus.add_cout;

  // Controller state, operand capture and per-nibble result assembly
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_idx    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.op_a;
            r_b     <= bus.op_sub ? ~bus.op_b : bus.op_b;
            r_carry <= bus.op_sub | bus.cin;
            r_idx   <= '0;
            r_state <= c_RUN;
          end
        end
        c_RUN: begin
          r_result[{r_idx, 2'b00} +: 4] <= bus.add_sum;
          r_carry <= bus.add_cout;
          r_idx   <= r_idx + IDX_W'(1);
          if (r_idx == c_LAST) begin
            r_cout  <= bus.add_cout;
            r_ovf   <= w_ovf;
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          if (bus.out_ready) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Adder slice drive: active only while running, quiet zeros otherwise
  always_comb begin
    bus.add_a   = 4'd0;
    bus.add_b   = 4'd0;
    bus.add_cin = 1'b0;
    if (r_state == c_RUN) begin
      bus.add_a   = w_a_nib;
      bus.add_b   = w_b_nib;
      bus.add_cin = r_carry;
    end
  end

  assign bus.in_ready  = (r_state == c_IDLE);
  assign bus.out_valid = (r_state == c_DONE);
  assign bus.result    = r_result;
  assign bus.carry_out = r_cout;
  assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_add_ctrl
// Purpose  : Self-checking bench for serial_add_ctrl with a 4-bit ripple
//            slice, directed literal cases and randomized operations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;
  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;

  serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // external 4-bit ripple-carry slice
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_left = 0;   // RUN cycles still to go
  int           m_k    = 0;   // nibbles already written
  bit           m_done = 1'b0;
  logic [W-1:0] m_a, m_bp, m_res;
  logic         m_c0, m_cout, m_ovf;
  logic [W:0]   m_sum;

  always @(posedge clk) begin
    if (rst) begin
      m_left = 0; m_k = 0; m_done = 1'b0;
      m_res = '0; m_cout = 1'b0; m_ovf = 1'b0;
    end else if (m_done) begin
      if (bus.out_ready) m_done = 1'b0;
    end else if (m_left > 0) begin
      m_res[4*m_k +: 4] = m_sum[4*m_k +: 4];
      m_k++;
      m_left--;
      if (m_left == 0) begin
        m_done = 1'b1;
        m_cout = m_sum[W];
        m_ovf  = (m_a[W-1] == m_bp[W-1]) && (m_sum[W-1] != m_a[W-1]);
      end
    end else if (bus.in_valid) begin
      m_a    = bus.op_a;
      m_bp   = bus.op_sub ? ~bus.op_b : bus.op_b;
      m_c0   = bus.op_sub ? 1'b1 : bus.cin;
      m_sum  = {1'b0, m_a} + {1'b0, m_bp} + {{W{1'b0}}, m_c0};
      m_left = NIBBLES;
      m_k    = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [W:0] e_msk, e_part;
  logic [3:0] e_a, e_b;
  logic       e_cin;

  always @(negedge clk) begin
    if (chk_en) begin
      e_a = 4'd0; e_b = 4'd0; e_cin = 1'b0;
      if (m_left > 0) begin
        e_msk  = ({{W{1'b0}}, 1'b1} << (4*m_k)) - 1'b1;
        e_part = ({1'b0, m_a} & e_msk) + ({1'b0, m_bp} & e_msk) + {{W{1'b0}}, m_c0};
        e_a    = m_a[4*m_k +: 4];
        e_b    = m_bp[4*m_k +: 4];
        e_cin  = e_part[4*m_k];
      end
      chk("in_ready",  64'(bus.in_ready),  64'(m_left == 0 && !m_done));
      chk("out_valid", 64'(bus.out_valid), 64'(m_done));
      chk("result",    64'(bus.result),    64'(m_res));
      chk("carry_out", 64'(bus.carry_out), 64'(m_cout));
      chk("overflow",  64'(bus.overflow),  64'(m_ovf));
      chk("add_a",     64'(bus.add_a),     64'(e_a));
      chk("add_b",     64'(bus.add_b),     64'(e_b));
      chk("add_cin",   64'(bus.add_cin),   64'(e_cin));
    end
  end

  // ---------------- stimulus helpers ----------------
  // called at a negedge; returns at the negedge after the accepting edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic c);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("issue_ready", 64'(bus.in_ready), 64'd1);
    bus.op_a = a; bus.op_b = b; bus.op_sub = sub; bus.cin = c;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_lit(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input logic c,
                         input logic [W-1:0] er, input logic ec, input logic ev,
                         input string nm, input bit ripple);
    int cnt = 0;
    bus.out_ready = 1'b0;
    issue(a, b, sub, c);
    while (!bus.out_valid && cnt < 50) begin
      if (ripple) chk({nm, "_ripple_cin"}, 64'(bus.add_cin), (cnt == 0) ? 64'd0 : 64'd1);
      @(negedge clk);
      cnt++;
    end
    chk({nm, "_latency"},   64'(cnt),           64'(NIBBLES));
    chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_result"},    64'(bus.result),    64'(er));
    chk({nm, "_carry"},     64'(bus.carry_out), 64'(ec));
    chk({nm, "_ovf"},       64'(bus.overflow),  64'(ev));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_released"},  64'(bus.out_valid), 64'd0);
    chk({nm, "_idle"},      64'(bus.in_ready),  64'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    bit  done;
    bus.in_valid = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.op_sub = 1'b0;
    bus.cin = 1'b0; bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result",    64'(bus.result),    64'd0);
    chk("rst_add_a",     64'(bus.add_a),     64'd0);
    chk("rst_add_cin",   64'(bus.add_cin),   64'd0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    run_lit(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, "add_basic", 1'b0);
    run_lit(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap",  1'b1);
    run_lit(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf",   1'b0);
    run_lit(16'h0003, 16'h0005, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, "sub_neg",   1'b0);
    run_lit(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0, "sub_pos",   1'b0);
    run_lit(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf",   1'b0);

    // hold while stalled, with in_valid toggling on new data
    bus.out_ready = 1'b0;
    issue(16'hABCD, 16'h1111, 1'b0, 1'b1);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.op_a = W'($urandom); bus.op_b = W'($urandom);
      @(negedge clk);
      chk("hold_result", 64'(bus.result),    64'h0000_0000_0000_BCDF);
      chk("hold_valid",  64'(bus.out_valid), 64'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("hold_release", 64'(bus.in_ready), 64'd1);

    // reset on the second RUN cycle
    issue(16'h4321, 16'h1234, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("midrst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("midrst_result",    64'(bus.result),    64'd0);
    chk("midrst_carry",     64'(bus.carry_out), 64'd0);
    run_lit(16'h4321, 16'h1234, 1'b0, 1'b1, 16'h5556, 1'b0, 1'b0, "after_rst", 1'b0);

    // randomized operations with random result stalls and ignored requests
    for (int i = 0; i < 1000; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      done = 1'b0;
      n = 0;
      while (!done && n < 200) begin
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.op_a      = W'($urandom);
        bus.op_b      = W'($urandom);
        bus.op_sub    = 1'($urandom_range(0, 1));
        bus.out_ready = bus.out_valid && ($urandom_range(0, 2) != 0);
        done          = bus.out_ready;
        @(negedge clk);
        n++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("rand_handshake", 64'(bus.in_ready), 64'd1);
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d, mismatched %0d", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
